// File: rtl/keypad_entry_receiver.sv
// Keypad digit receiver: loadn synchroniser/debouncer, 4-digit mm:ss entry buffer, valid/ready offer.
// Optional MICROWAVE_SEC_NORMALIZE_EN: commit with seconds >= 60 normalises into minutes.
module keypad_entry_receiver #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter logic [3:0]  MAX_SEC_TENS    = 4'd5
) (
  input  logic       clock,
  input  logic       clearn,
  input  logic [3:0] data,
  input  logic       loadn,
  input  logic       enablen,
  input  logic       entry_clr,
  input  logic       commit,
  input  logic       load_ready,
  output logic       load_valid,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] mins,
  output logic [3:0] min_tens,
  output logic [2:0] digit_count,
  output logic       entry_err
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  typedef enum logic [1:0] {S_EMPTY, S_ENTRY, S_OFFER} state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_loadn_s;
  logic                   r_armed;
  logic [CW-1:0]          r_db_cnt;
  logic                   r_acc_valid;
  logic [3:0]             r_acc_digit;

  state_t     r_state, w_state;
  logic [3:0] r_min_tens, r_mins, r_sec_tens, r_sec_ones;
  logic [3:0] w_min_tens, w_mins, w_sec_tens, w_sec_ones;
  logic [2:0] r_cnt, w_cnt;
  logic       r_err, w_err;
  logic       w_commit_ok;

  assign w_loadn_s = r_sync[SYNC_STAGES-1];

  // Counts consecutive samples at the level that flips the arm state: low while armed, high while not.
  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      r_sync      <= '1;
      r_armed     <= 1'b1;
      r_db_cnt    <= '0;
      r_acc_valid <= 1'b0;
      r_acc_digit <= '0;
    end else begin
      r_sync      <= {r_sync[SYNC_STAGES-2:0], loadn};
      r_acc_valid <= 1'b0;
      if (w_loadn_s == !r_armed) begin
        if (r_db_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          r_db_cnt <= '0;
          r_armed  <= !r_armed;
          if (r_armed) begin
            r_acc_valid <= 1'b1;
            r_acc_digit <= data;
          end
        end else begin
          r_db_cnt <= r_db_cnt + 1'b1;
        end
      end else begin
        r_db_cnt <= '0;
      end
    end
  end

  assign w_commit_ok = commit & ~enablen;

  always_comb begin
    w_state    = r_state;
    w_min_tens = r_min_tens;
    w_mins     = r_mins;
    w_sec_tens = r_sec_tens;
    w_sec_ones = r_sec_ones;
    w_cnt      = r_cnt;
    w_err      = 1'b0;
    if (entry_clr) begin
      w_state    = S_EMPTY;
      w_min_tens = '0;
      w_mins     = '0;
      w_sec_tens = '0;
      w_sec_ones = '0;
      w_cnt      = '0;
    end else if (r_state == S_OFFER && load_ready) begin
      w_state    = S_EMPTY;
      w_min_tens = '0;
      w_mins     = '0;
      w_sec_tens = '0;
      w_sec_ones = '0;
      w_cnt      = '0;
      w_err      = r_acc_valid & ~enablen;
    end else begin
      if (w_commit_ok && r_state == S_ENTRY) begin
        if (r_sec_tens <= MAX_SEC_TENS) begin
          w_state = S_OFFER;
        end else begin
`ifdef MICROWAVE_SEC_NORMALIZE_EN
          if (r_sec_tens >= 4'd6 && !(r_min_tens == 4'd9 && r_mins == 4'd9)) begin
            w_sec_tens = r_sec_tens - 4'd6;
            if (r_mins == 4'd9) begin
              w_mins     = '0;
              w_min_tens = r_min_tens + 4'd1;
            end else begin
              w_mins = r_mins + 4'd1;
            end
            w_state = S_OFFER;
          end else begin
            w_err = 1'b1;
          end
`else
          w_err = 1'b1;
`endif
        end
      end
      // A digit landing on a commit edge loses to the commit and is reported.
      if (r_acc_valid && !enablen) begin
        if (w_commit_ok || r_acc_digit > 4'd9 || r_state == S_OFFER || r_cnt == 3'd4) begin
          w_err = 1'b1;
        end else begin
          w_min_tens = r_mins;
          w_mins     = r_sec_tens;
          w_sec_tens = r_sec_ones;
          w_sec_ones = r_acc_digit;
          w_cnt      = r_cnt + 3'd1;
          w_state    = S_ENTRY;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      r_state    <= S_EMPTY;
      r_min_tens <= '0;
      r_mins     <= '0;
      r_sec_tens <= '0;
      r_sec_ones <= '0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_min_tens <= w_min_tens;
      r_mins     <= w_mins;
      r_sec_tens <= w_sec_tens;
      r_sec_ones <= w_sec_ones;
      r_cnt      <= w_cnt;
      r_err      <= w_err;
    end
  end

  assign load_valid  = (r_state == S_OFFER);
  assign min_tens    = r_min_tens;
  assign mins        = r_mins;
  assign sec_tens    = r_sec_tens;
  assign sec_ones    = r_sec_ones;
  assign digit_count = r_cnt;
  assign entry_err   = r_err;

endmodule
